// File: rtl/clk_div_if.sv
// Ratio/output bundle for the programmable clock divider.
// The master side programs the ratio and receives the divided clock.
interface clk_div_if #(
   parameter int DIV_W = 8
);
   logic [DIV_W-1:0] div_num;
   logic             clk_out;

   modport master (output div_num, input clk_out);
   modport slave  (input div_num, output clk_out);
endinterface

// File: rtl/clk_div.sv
// Programmable integer clock divider with 50% duty for even and odd ratios.
//
// state (r_div_q / r_byp_sel)  | meaning
// -----------------------------+-----------------------------------------------
// div_q = 0                    | disabled, clk_out held low, counter held at 0
// div_q = 1, byp_sel = 1       | bypass, clk_out = source clock
// div_q >= 2, even             | clk_out = pos_q, high for div_q/2 cycles
// div_q >= 3, odd              | clk_out = pos_q | neg_q, high for div_q/2 cycles
//
// The active ratio reloads only when a period wraps, or every cycle while
// the divider is disabled or bypassed, so a running period is never cut short.
// The bypass select moves on a falling edge with the divided output low, when
// both mux inputs are low. While the bypass is still selected the divided
// output is suppressed; leaving bypass therefore costs one divided period.
module clk_div #(
   parameter int DIV_W = 8
) (
   input  logic      i_clk_sys,
   input  logic      i_rst_b,
   clk_div_if.slave  if_div
);

   logic [DIV_W-1:0] w_div_num;
   logic [DIV_W-1:0] r_div_q;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_div_nxt;
   logic [DIV_W-1:0] w_cnt_nxt;
   logic             w_load;
   logic             w_pos_nxt;
   logic             r_pos_q;
   logic             r_neg_q;
   logic             r_byp_sel;
   logic             w_div_out;

   assign w_div_num = if_div.div_num;

   // Next ratio and count; pos_q is computed from the post-edge count so the
   // output rises on the same edge that starts a period
   always_comb begin
      w_load    = (r_div_q <= DIV_W'(1)) || (r_cnt == r_div_q - DIV_W'(1));
      w_div_nxt = r_div_q;
      w_cnt_nxt = r_cnt + DIV_W'(1);
      if (w_load) begin
         w_div_nxt = w_div_num;
         w_cnt_nxt = '0;
      end
      w_pos_nxt = (w_div_nxt >= DIV_W'(2)) &&
                  (w_cnt_nxt < (w_div_nxt >> 1)) &&
                  !r_byp_sel;
   end

   // Rising-edge counter, active ratio and high-phase flag
   always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
      if (!i_rst_b) begin
         r_div_q <= '0;
         r_cnt   <= '0;
         r_pos_q <= 1'b0;
      end else begin
         r_div_q <= w_div_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pos_q <= w_pos_nxt;
      end
   end

   // Falling-edge helpers: half-cycle extension for odd ratios, bypass select
   always_ff @(negedge i_clk_sys or negedge i_rst_b) begin
      if (!i_rst_b) begin
         r_neg_q   <= 1'b0;
         r_byp_sel <= 1'b0;
      end else begin
         r_neg_q <= r_pos_q;
         if (!w_div_out) begin
            r_byp_sel <= (r_div_q == DIV_W'(1));
         end
      end
   end

   // neg_q only matters for odd ratios; it is low whenever div_q changes parity
   assign w_div_out = r_pos_q | (r_neg_q & r_div_q[0]);

   // Output mux: source clock in bypass, divided clock otherwise
   assign if_div.clk_out = r_byp_sel ? i_clk_sys : w_div_out;

endmodule

// File: tb/tb_clk_div.sv
// Randomized and directed bench for clk_div against a half-cycle period model.
`timescale 1ns/1ps
module tb_clk_div;

   logic clk;
   logic rst_b;
   int   n_checks;
   int   n_errors;

   clk_div_if #(.DIV_W(8)) u_if();

   clk_div #(.DIV_W(8)) u_dut (
      .i_clk_sys (clk),
      .i_rst_b   (rst_b),
      .if_div    (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a period of ratio N spans 2N clk half-cycles, high for the
   // first N. A new ratio is taken at a rising edge that starts a period, or
   // at any rising edge while the model is idle.
   int m_n;
   int m_p;

   task automatic model_pos(input int dn);
      if (m_n < 2 || m_p + 1 == 2 * m_n) begin
         m_n = dn;
         m_p = 0;
      end else begin
         m_p++;
      end
   endtask

   task automatic model_neg();
      if (m_n >= 2) m_p++;
   endtask

   function automatic logic model_out();
      return (m_n >= 2) && (m_p < m_n);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clk cycle with a model comparison after each edge
   task automatic run_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_pos(int'(u_if.div_num));
         #1 check_val(tag, 32'(u_if.clk_out), 32'(model_out()));
         @(negedge clk);
         model_neg();
         #1 check_val(tag, 32'(u_if.clk_out), 32'(model_out()));
      end
   endtask

   // Shortest clk_out high or low time outside of reset
   time last_t;
   time min_w;
   bit  edge_valid;
   int  n_edges;

   initial begin
      min_w      = 1000000;
      last_t     = 0;
      edge_valid = 1'b0;
      n_edges    = 0;
   end

   always @(u_if.clk_out) begin
      if (rst_b && edge_valid) begin
         if ($time - last_t < min_w) min_w = $time - last_t;
         n_edges++;
      end
      last_t     = $time;
      edge_valid = rst_b;
   end

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      m_n          = 0;
      m_p          = 0;
      rst_b        = 1'b0;
      u_if.div_num = 8'd0;

      #3 check_val("rst_out", 32'(u_if.clk_out), 32'd0);
      repeat (2) @(negedge clk);
      #1 check_val("rst_out_hold", 32'(u_if.clk_out), 32'd0);
      #1 rst_b = 1'b1;

      run_cycles(20, "idle_n0");

      u_if.div_num = 8'd2;  run_cycles(7,  "n2");
      u_if.div_num = 8'd4;  run_cycles(13, "n2_to_n4");
      u_if.div_num = 8'd3;  run_cycles(9,  "n3");
      u_if.div_num = 8'd5;  run_cycles(12, "n5");
      u_if.div_num = 8'd0;  run_cycles(12, "n5_to_n0");

      // Reset during the high phase of a ratio-4 period
      u_if.div_num = 8'd4;  run_cycles(2, "n4_pre_rst");
      check_val("n4_high_before_rst", 32'(u_if.clk_out), 32'd1);
      #2 rst_b = 1'b0;
      #1 check_val("rst_drop", 32'(u_if.clk_out), 32'd0);
      m_n = 0;
      m_p = 0;
      @(posedge clk);
      #1 check_val("rst_hold", 32'(u_if.clk_out), 32'd0);
      @(negedge clk);
      #2 rst_b = 1'b1;
      @(posedge clk);
      model_pos(int'(u_if.div_num));
      #1 check_val("rst_first_rise", 32'(u_if.clk_out), 32'd1);
      @(negedge clk);
      model_neg();
      run_cycles(10, "n4_after_rst");

      // Bypass: clk_out follows clk after the select settles
      u_if.div_num = 8'd0;  run_cycles(6, "pre_bypass");
      u_if.div_num = 8'd1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 check_val("byp_hi", 32'(u_if.clk_out), 32'd1);
         @(negedge clk);
         #1 check_val("byp_lo", 32'(u_if.clk_out), 32'd0);
      end
      u_if.div_num = 8'd0;
      repeat (3) @(negedge clk);
      #1;
      check_val("byp_exit", 32'(u_if.clk_out), 32'd0);
      m_n = 0;
      m_p = 0;

      // Random ratios 0 and 2..9, changed at arbitrary points in a period
      for (int s = 0; s < 40; s++) begin
         int r;
         r = int'($urandom_range(0, 8));
         if (r >= 1) r = r + 1;
         u_if.div_num = 8'(r);
         run_cycles(int'($urandom_range(3, 30)), "rand");
      end

      u_if.div_num = 8'd255; run_cycles(600, "n255");
      u_if.div_num = 8'd0;   run_cycles(300, "n255_to_n0");

      check_val("edges_seen", 32'(n_edges > 20), 32'd1);
      check_val("min_pulse", 32'(min_w >= 5), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
